// File: rtl/uart_rx_deserializer.sv
// Receive-only 8N1 UART deserializer: one-cycle rdata_valid strobe per correctly framed byte.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as the majority of three mid-bit samples.
module uart_rx_deserializer #(
    parameter int unsigned FMAX_MHz  = 27,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rdata,
    output logic       rdata_valid
);

    localparam int unsigned CLKS_PER_BIT = (FMAX_MHz * 1000000) / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    // The synchronizer and the idle-detect cycle already account for two clocks of the half bit.
    localparam int unsigned MID_CNT      = CLKS_PER_BIT / 2 - 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned MID_DECIDE   = MID_CNT + 1;
`else
    localparam int unsigned MID_DECIDE   = MID_CNT;
`endif
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_DECIDE);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             rx_meta_q, rx_s_q;
    logic             sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s_q};
        sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        sample = rx_s_q;
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        armed_d       = armed_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == MID_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sample ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d             = '0;
                    shift_d[bit_idx_q] = sample;
                    bit_idx_d         = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (sample) begin
                        rdata_d       = shift_q;
                        rdata_valid_d = 1'b1;
                    end else begin
                        // Framing error or break: stay disarmed until the line returns high.
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b1;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

    valid_single_cycle: assert property (
        @(posedge clk) disable iff (!rst_n) rdata_valid_q |=> !rdata_valid_q
    );

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed vector table, corner sequences
// and random frames compared against a byte-level model of the 8N1 framing rules.
module tb_uart_rx_deserializer;

    localparam int unsigned FMAX = 27;
    localparam int unsigned BAUD = 115200;
    localparam int          CPB  = (27 * 1000000) / 115200;
    localparam int          LAT_MIN = (CPB * 19) / 2 + 2 - 2;
    localparam int          LAT_MAX = (CPB * 19) / 2 + 2 + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rdata;
    logic       rdata_valid;

    uart_rx_deserializer #(
        .FMAX_MHz (FMAX),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rdata      (rdata),
        .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pulse_count = 0;
    int         width_err = 0;
    int         last_pulse_cyc = 0;
    logic       prev_v = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rdata_valid) begin
            pulse_count    <= pulse_count + 1;
            last_pulse_cyc <= cyc;
            got_q.push_back(rdata);
            if (prev_v) width_err <= width_err + 1;
        end
        prev_v <= rdata_valid;
    end

    int total = 0;
    int bad = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 uart_rx = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;
        int         exp_pulses;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] part_byte;
    logic [7:0] exp_q[$];

    initial begin
        int n0;
        int base;
        logic [7:0] d;
        logic stop;
        int gap;

        vecs[0] = '{8'h55, 1'b1, 2, 1, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0, 1, 8'hA3};
        vecs[2] = '{8'h00, 1'b1, 0, 1, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 2, 1, 8'hFF};
        vecs[4] = '{8'h5A, 1'b0, 2, 0, 8'hFF};
        vecs[5] = '{8'h96, 1'b1, 1, 1, 8'h96};

        repeat (5) @(posedge clk);
        #1;
        check("reset rdata", rdata, 8'h00);
        check("reset valid", rdata_valid, 1'b0);
        rst_n = 1'b1;
        repeat (5000) @(posedge clk);
        #1;
        check("idle pulses", pulse_count, 0);
        check("idle rdata", rdata, 8'h00);

        for (int v = 0; v < 6; v++) begin
            n0 = pulse_count;
            send_frame(vecs[v].data, vecs[v].stop);
            idle_bits(vecs[v].idle);
            check($sformatf("vec%0d pulses", v), pulse_count - n0, vecs[v].exp_pulses);
            check($sformatf("vec%0d rdata", v), rdata, vecs[v].exp_rdata);
            if (vecs[v].exp_pulses == 1)
                check_range($sformatf("vec%0d latency", v), last_pulse_cyc - start_cyc,
                            LAT_MIN, LAT_MAX);
        end

        // Short low glitch on an idle line.
        n0 = pulse_count;
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (50) @(posedge clk);
        #1 uart_rx = 1'b1;
        idle_bits(2);
        check("glitch pulses", pulse_count - n0, 0);
        check("glitch rdata", rdata, 8'h96);
        n0 = pulse_count;
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        check("after glitch pulses", pulse_count - n0, 1);
        check("after glitch rdata", rdata, 8'h3C);

        // Framing error followed by a long break.
        n0 = pulse_count;
        send_frame(8'h81, 1'b0);
        repeat (20) drive_bit(1'b0);
        idle_bits(2);
        check("break pulses", pulse_count - n0, 0);
        check("break rdata", rdata, 8'h3C);
        n0 = pulse_count;
        send_frame(8'h7E, 1'b1);
        idle_bits(1);
        check("after break pulses", pulse_count - n0, 1);
        check("after break rdata", rdata, 8'h7E);

        // Reset during data bit 4.
        part_byte = 8'hC3;
        n0 = pulse_count;
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) drive_bit(part_byte[i]);
        @(posedge clk);
        #1 uart_rx = part_byte[4];
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset rdata", rdata, 8'h00);
        check("midreset valid", rdata_valid, 1'b0);
        uart_rx = 1'b1;
        rst_n = 1'b1;
        idle_bits(3);
        check("post reset pulses", pulse_count - n0, 0);
        check("post reset rdata", rdata, 8'h00);
        n0 = pulse_count;
        send_frame(8'h12, 1'b1);
        idle_bits(1);
        check("after reset pulses", pulse_count - n0, 1);
        check("after reset rdata", rdata, 8'h12);

        // Random frames: only frames with a high stop bit may deliver a byte.
        base = got_q.size();
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            send_frame(d, stop);
            idle_bits(gap);
            if (stop) exp_q.push_back(d);
        end
        idle_bits(1);
        check("rand count", got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("rand byte%0d", i), got_q[base + i], exp_q[i]);
        end

        check("pulse width", width_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
